// File: rtl/hazard_pkg.sv
// Shared types and constants for the rv32im hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MDU_BUSY = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;

  localparam int CNT_W       = 6;
  localparam int MUL_LAT_DEF = 2;
  localparam int DIV_LAT_DEF = 33;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/mdu_seq.sv
// MDU sequencer: start pulse, latency countdown and result-valid timing.
// A single-cycle op reports valid in the following RUN cycle; longer ops count down in MDU_BUSY.
module mdu_seq
  import hazard_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic run_i,
  input  logic busy_i,
  input  logic ex_is_mul_i,
  input  logic ex_is_div_i,
  output logic start_o,
  output logic valid_o,
  output logic stall_o,
  output logic enter_busy_o,
  output logic leave_busy_o
);

  localparam logic [CNT_W-1:0] MUL_L = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0] DIV_L = CNT_W'(DIV_LAT);

  logic [CNT_W-1:0] cnt_q, cnt_d, lat;
  logic             valid1_q, valid1_d;
  logic             op, long_op, cnt_zero;

  always_comb begin
    lat          = ex_is_div_i ? DIV_L : MUL_L;
    op           = ex_is_mul_i | ex_is_div_i;
    long_op      = (lat != CNT_W'(1));
    cnt_zero     = (cnt_q == '0);
    // A pending single-cycle result blocks re-start while the finished op is still in EX.
    start_o      = run_i & op & ~valid1_q;
    enter_busy_o = start_o & long_op;
    leave_busy_o = busy_i & cnt_zero;
    valid_o      = (run_i & valid1_q) | leave_busy_o;
    stall_o      = start_o | (busy_i & ~cnt_zero);

    cnt_d    = cnt_q;
    valid1_d = valid1_q;
    if (enter_busy_o) begin
      cnt_d = lat - CNT_W'(1);
    end else if (busy_i && !cnt_zero) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    if (start_o && !long_op) begin
      valid1_d = 1'b1;
    end else if (run_i) begin
      valid1_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      valid1_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      valid1_q <= valid1_d;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait freeze, MDU sequencing, branch squash, load-use stall.
// Optional perf counters under HAZARD_PERF_CNT_EN; outputs are combinational, all 0 during reset.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int R       = 5,
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [R-1:0] dec_addr1,
  input  logic [R-1:0] dec_addr2,
  input  logic         dec_use_rs1,
  input  logic         dec_use_rs2,
  input  logic [R-1:0] ex_rd,
  input  logic         ex_is_load,
  input  logic         ex_is_mul,
  input  logic         ex_is_div,
  input  logic         ex_br_taken,
  input  logic         mem_req,
  input  logic         mem_ready,
  output logic         pc_stall,
  output logic         dec_stall,
  output logic         ex_stall,
  output logic         ex_bubble,
  output logic         dec_flush,
  output logic         mem_stall,
  output logic         mdu_start,
  output logic         mdu_valid
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]  perf_ld_stall,
  output logic [31:0]  perf_mdu_stall,
  output logic [31:0]  perf_mem_stall
`endif
);

  state_e state_q, state_d, saved_q, saved_d, eff;
  logic   mem_wait, run, busy, mdu_op, hazard, br_flush, ld_use;
  logic   mdu_stall, enter_busy, leave_busy;

  mdu_seq #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_mdu (
    .clk          (clk),
    .reset        (reset),
    .run_i        (run),
    .busy_i       (busy),
    .ex_is_mul_i  (ex_is_mul),
    .ex_is_div_i  (ex_is_div),
    .start_o      (mdu_start),
    .valid_o      (mdu_valid),
    .stall_o      (mdu_stall),
    .enter_busy_o (enter_busy),
    .leave_busy_o (leave_busy)
  );

  always_comb begin
    // On the release cycle of a memory wait the saved state acts as if never left.
    eff      = (state_q == MEM_WAIT) ? saved_q : state_q;
    mem_wait = !reset && ((state_q == MEM_WAIT) ? !mem_ready : (mem_req && !mem_ready));
    run      = !reset && !mem_wait && (eff == RUN);
    busy     = !reset && !mem_wait && (eff == MDU_BUSY);
    mdu_op   = ex_is_mul | ex_is_div;
    hazard   = ex_is_load && (ex_rd != '0) &&
               ((dec_use_rs1 && (dec_addr1 == ex_rd)) || (dec_use_rs2 && (dec_addr2 == ex_rd)));
    br_flush = run && !mdu_op && ex_br_taken;
    ld_use   = run && !mdu_op && !ex_br_taken && hazard;

    pc_stall  = mem_wait || mdu_stall || ld_use;
    dec_stall = mem_wait || mdu_stall || ld_use;
    ex_stall  = mem_wait || mdu_stall;
    ex_bubble = br_flush || ld_use;
    dec_flush = br_flush;
    mem_stall = mem_wait;

    state_d = eff;
    saved_d = saved_q;
    if (mem_wait) begin
      state_d = MEM_WAIT;
      saved_d = eff;
    end else if (enter_busy) begin
      state_d = MDU_BUSY;
    end else if (leave_busy) begin
      state_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      saved_q <= RUN;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_ld_q, perf_mdu_q, perf_mem_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_ld_q  <= '0;
      perf_mdu_q <= '0;
      perf_mem_q <= '0;
    end else begin
      perf_ld_q  <= perf_ld_q + 32'(ld_use);
      perf_mdu_q <= perf_mdu_q + 32'(mdu_stall);
      perf_mem_q <= perf_mem_q + 32'(mem_wait);
    end
  end

  assign perf_ld_stall  = perf_ld_q;
  assign perf_mdu_stall = perf_mdu_q;
  assign perf_mem_stall = perf_mem_q;
`endif

endmodule
